branch_unit: RTL

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_pkg.sv | 24 ++
 rtl/cmpop_pkg.sv | 13 +
 rtl/branch_unit_if.sv | 28 ++
 rtl/cmp.sv | 24 ++
 rtl/branch_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Branch-unit types, the squash-depth default and the compare-opcode legality check.
package branch_pkg;
   import cmpop_pkg::*;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      BRANCH = 2'd1,
      JAL    = 2'd2,
      JALR   = 2'd3
   } br_type_t;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } squash_state_t;

   localparam int unsigned SQUASH_DEPTH_DEF = 2;

   function automatic logic cmpop_legal(input logic [2:0] op);
      return (op == CMP_BEQ)  || (op == CMP_BNE)  || (op == CMP_BLT) ||
             (op == CMP_BGE)  || (op == CMP_BLTU) || (op == CMP_BGEU);
   endfunction

endpackage

// File: rtl/cmpop_pkg.sv
// Shared compare-opcode encodings used by every block that drives the cmp comparator.
package cmpop_pkg;

   typedef enum logic [2:0] {
      CMP_BEQ  = 3'd0,
      CMP_BNE  = 3'd1,
      CMP_BLT  = 3'd4,
      CMP_BGE  = 3'd5,
      CMP_BLTU = 3'd6,
      CMP_BGEU = 3'd7
   } cmpop_t;

endpackage

// File: rtl/branch_unit_if.sv
// Request/response bundle of the branch unit, with master (issuer) and slave (unit) views.
interface branch_unit_if;
   logic        valid;
   logic        ready;
   logic [31:0] pc;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] imm;
   logic [1:0]  br_type;
   logic [2:0]  cmpop;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] link;
   logic        misalign;

   modport master (
      output valid, pc, rs1, rs2, imm, br_type, cmpop, rsp_ready,
      input  ready, rsp_valid, redirect, target, link, misalign
   );

   modport slave (
      input  valid, pc, rs1, rs2, imm, br_type, cmpop, rsp_ready,
      output ready, rsp_valid, redirect, target, link, misalign
   );
endinterface

// File: rtl/cmp.sv
// Integer comparator for conditional branches; unknown opcodes yield 0.
module cmp
   import cmpop_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   output logic        res_o
);

   always_comb begin
      res_o = 1'b0;
      case (op_i)
         CMP_BEQ:  res_o = (a_i == b_i);
         CMP_BNE:  res_o = (a_i != b_i);
         CMP_BLT:  res_o = ($signed(a_i) <  $signed(b_i));
         CMP_BGE:  res_o = ($signed(a_i) >= $signed(b_i));
         CMP_BLTU: res_o = (a_i <  b_i);
         CMP_BGEU: res_o = (a_i >= b_i);
         default:  res_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Resolves branches/jumps with a one-entry result slot and discards the
// SQUASH_DEPTH wrong-path inputs that follow any redirect or misaligned target.
module branch_unit
   import branch_pkg::*;
#(
   parameter int unsigned SQUASH_DEPTH = SQUASH_DEPTH_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_imm,
   input  logic [1:0]  i_br_type,
   input  logic [2:0]  i_cmpop,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_redirect,
   output logic [31:0] o_target,
   output logic [31:0] o_link,
   output logic        o_misalign
);

   localparam logic [2:0] DEPTH = 3'(SQUASH_DEPTH);

   squash_state_t state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          redirect_q, redirect_d;
   logic          misalign_q, misalign_d;
   logic [31:0]   target_q, target_d;
   logic [31:0]   link_q, link_d;

   logic          cmp_res;
   logic          accept;
   logic          taken_c, misalign_c, redirect_c;
   logic [31:0]   dest_c, link_c, out_target_c;

   cmp u_cmp (
      .a_i   (i_rs1),
      .b_i   (i_rs2),
      .op_i  (i_cmpop),
      .res_o (cmp_res)
   );

   // Squash inputs are consumed even while the result slot is stalled.
   assign o_ready = (cnt_q != 3'd0) || !valid_q || i_ready;
   assign accept  = i_valid && o_ready;

   always_comb begin
      taken_c = 1'b0;
      dest_c  = i_pc + i_imm;
      case (br_type_t'(i_br_type))
         BRANCH:  taken_c = cmp_res && cmpop_legal(i_cmpop);
         JAL:     taken_c = 1'b1;
         JALR: begin
            taken_c = 1'b1;
            dest_c  = (i_rs1 + i_imm) & ~32'h1;
         end
         default: taken_c = 1'b0;
      endcase
      link_c       = i_pc + 32'd4;
      misalign_c   = taken_c && (dest_c[1:0] != 2'b00);
      redirect_c   = taken_c && !misalign_c;
      out_target_c = taken_c ? dest_c : link_c;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (accept && (redirect_c || misalign_c)) begin
               cnt_d   = DEPTH;
               state_d = SQUASH;
            end
         end
         SQUASH: begin
            if (accept) begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      valid_d    = valid_q;
      redirect_d = redirect_q;
      misalign_d = misalign_q;
      target_d   = target_q;
      link_d     = link_q;
      if (accept && (state_q == RUN)) begin
         valid_d    = 1'b1;
         redirect_d = redirect_c;
         misalign_d = misalign_c;
         target_d   = out_target_c;
         link_d     = link_c;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
         target_q   <= '0;
         link_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
         target_q   <= target_d;
         link_q     <= link_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_redirect = redirect_q;
   assign o_misalign = misalign_q;
   assign o_target   = target_q;
   assign o_link     = link_q;

endmodule
